// File: rtl/c1541_gcr_dec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : c1541_pkg
//  Description : Shared definitions for the 1541 GCR track decoder.
//                Provides the sync length, the block ID bytes, the decoder
//                state encoding, and the GCR 5-bit to 4-bit decode function.
//                The decode function returns {valid, nibble}.
//  Revision    : 1.0 - initial release
// ============================================================================
package c1541_pkg;

    // A run of this many consecutive ones marks a sync field
    localparam int SYNC_LEN = 10;

    // Block identifiers: first byte after sync
    localparam logic [7:0] c_ID_HDR  = 8'h08;
    localparam logic [7:0] c_ID_DATA = 8'h07;

    // Highest sector number that any zone of a 1541 disk uses
    localparam logic [7:0] c_MAX_SECTOR = 8'd20;

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_SYNC = 3'd1,
        ST_ID   = 3'd2,
        ST_HDR  = 3'd3,
        ST_DATA = 3'd4,
        ST_SKIP = 3'd5
    } gcr_state_e;

    localparam logic [2:0] c_ST_HUNT = 3'(ST_HUNT);
    localparam logic [2:0] c_ST_SYNC = 3'(ST_SYNC);
    localparam logic [2:0] c_ST_ID   = 3'(ST_ID);
    localparam logic [2:0] c_ST_HDR  = 3'(ST_HDR);
    localparam logic [2:0] c_ST_DATA = 3'(ST_DATA);
    localparam logic [2:0] c_ST_SKIP = 3'(ST_SKIP);

    // Standard 1541 GCR table, inverse direction. Codes outside the table
    // return valid = 0 and nibble = 0.
    function automatic logic [4:0] gcr_decode(input logic [4:0] code);
        logic [4:0] w_res;
        case (code)
            5'b01010: w_res = {1'b1, 4'h0};
            5'b01011: w_res = {1'b1, 4'h1};
            5'b10010: w_res = {1'b1, 4'h2};
            5'b10011: w_res = {1'b1, 4'h3};
            5'b01110: w_res = {1'b1, 4'h4};
            5'b01111: w_res = {1'b1, 4'h5};
            5'b10110: w_res = {1'b1, 4'h6};
            5'b10111: w_res = {1'b1, 4'h7};
            5'b01001: w_res = {1'b1, 4'h8};
            5'b11001: w_res = {1'b1, 4'h9};
            5'b11010: w_res = {1'b1, 4'hA};
            5'b11011: w_res = {1'b1, 4'hB};
            5'b01101: w_res = {1'b1, 4'hC};
            5'b11101: w_res = {1'b1, 4'hD};
            5'b11110: w_res = {1'b1, 4'hE};
            5'b10101: w_res = {1'b1, 4'hF};
            default:  w_res = {1'b0, 4'h0};
        endcase
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/c1541_gcr_dec_if.sv
`default_nettype none
// ============================================================================
//  Module      : c1541_gcr_dec_if
//  Description : Bit-stream input and decode-result bundle of the GCR decoder.
//                master : drives bit_en, bit_in, track; observes results.
//                slave  : the decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface c1541_gcr_dec_if;
    logic       bit_en;      // one GCR bit cell per strobe
    logic       bit_in;      // raw GCR bit, MSB first
    logic [5:0] track;       // current head track
    logic       in_sync;     // run of ones >= 10
    logic       hdr_valid;   // pulse: good header
    logic       hdr_err;     // pulse: bad header
    logic [4:0] hdr_sector;  // sector of last good header
    logic [5:0] hdr_track;   // track of last good header
    logic [7:0] ram_addr;    // data byte index
    logic [7:0] ram_di;      // decoded data byte
    logic       ram_we;      // pulse: write ram_di at ram_addr
    logic       sec_done;    // pulse: data block good
    logic       sec_err;     // pulse: data block bad or aborted

    modport master (
        output bit_en, bit_in, track,
        input  in_sync, hdr_valid, hdr_err, hdr_sector, hdr_track,
               ram_addr, ram_di, ram_we, sec_done, sec_err
    );

    modport slave (
        input  bit_en, bit_in, track,
        output in_sync, hdr_valid, hdr_err, hdr_sector, hdr_track,
               ram_addr, ram_di, ram_we, sec_done, sec_err
    );
endinterface
`default_nettype wire

// File: rtl/c1541_gcr_dec_sync_det.sv
`default_nettype none
// ============================================================================
//  Module      : c1541_gcr_sync_det
//  Description : Sync detector and 10-bit GCR byte framer.
//    clk32         in   system clock
//    reset         in   asynchronous active-high reset
//    i_bit_en      in   bit strobe
//    i_bit_in      in   raw GCR bit
//    o_in_sync     out  current run of ones is SYNC_LEN or longer
//    o_sync_stb    out  this strobe completes a sync run (comb.)
//    o_frame_start out  this strobe carries the first 0 after sync (comb.)
//    o_byte_stb    out  this strobe is the 10th bit of a byte (comb.)
//    o_code        out  the 10 GCR bits of that byte, first bit in [9]
//  Revision    : 1.0 - initial release
// ============================================================================
module c1541_gcr_sync_det
    import c1541_pkg::*;
(
    input  logic       clk32,
    input  logic       reset,
    input  logic       i_bit_en,
    input  logic       i_bit_in,
    output logic       o_in_sync,
    output logic       o_sync_stb,
    output logic       o_frame_start,
    output logic       o_byte_stb,
    output logic [9:0] o_code
);

    logic [3:0] r_ones;     // saturates at SYNC_LEN
    logic [8:0] r_shift;    // last nine bits received
    logic       r_framing;
    logic [3:0] r_bitcnt;   // bits of the current byte already received
    logic       w_run_full;

    assign w_run_full    = (r_ones == 4'(SYNC_LEN));
    assign o_in_sync     = w_run_full;
    assign o_sync_stb    = i_bit_en & i_bit_in & (r_ones == 4'(SYNC_LEN - 1));
    // The zero ending a sync run is the MSB of the first quintuple, so it
    // starts framing in the same strobe rather than being dropped.
    assign o_frame_start = i_bit_en & ~i_bit_in & w_run_full;
    // A sync run landing on a byte boundary takes precedence over the byte.
    assign o_byte_stb    = i_bit_en & r_framing & (r_bitcnt == 4'd9) & ~o_sync_stb;
    assign o_code        = {r_shift, i_bit_in};

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            r_ones    <= 4'd0;
            r_shift   <= 9'd0;
            r_framing <= 1'b0;
            r_bitcnt  <= 4'd0;
        end else if (i_bit_en) begin
            r_shift <= {r_shift[7:0], i_bit_in};

            if (!i_bit_in) begin
                r_ones <= 4'd0;
            end else if (!w_run_full) begin
                r_ones <= r_ones + 4'd1;
            end

            if (o_sync_stb) begin
                r_framing <= 1'b0;
                r_bitcnt  <= 4'd0;
            end else if (o_frame_start) begin
                r_framing <= 1'b1;
                r_bitcnt  <= 4'd1;
            end else if (r_framing) begin
                r_bitcnt <= (r_bitcnt == 4'd9) ? 4'd0 : r_bitcnt + 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/c1541_gcr_dec.sv
`default_nettype none
// ============================================================================
//  Module      : c1541_gcr_dec
//  Description : Commodore 1541 GCR track decoder. Finds sync, frames and
//                decodes GCR bytes, checks headers and writes data blocks
//                to a 256-byte sector buffer.
//    clk32   in     32 MHz system clock
//    reset   in     asynchronous active-high reset
//    bus     slave  c1541_gcr_dec_if (bit stream in, decode results out)
//  Build option : C1541_GCR_DEC_TRACK_CHECK_EN - when defined, a header
//                 whose track differs from bus.track is rejected.
//  Revision    : 1.0 - initial release
// ============================================================================
module c1541_gcr_dec
    import c1541_pkg::*;
(
    input  logic              clk32,
    input  logic              reset,
    c1541_gcr_dec_if.slave    bus
);

    logic       w_in_sync;
    logic       w_sync_stb;
    logic       w_frame_start;
    logic       w_byte_stb;
    logic [9:0] w_code;
    logic [4:0] w_hi;
    logic [4:0] w_lo;
    logic [7:0] w_byte;
    logic       w_code_ok;
    logic       w_bad;
    logic       w_cks_ok;
    logic       w_trk_match;

    logic [2:0] r_state;
    logic [8:0] r_bytecnt;
    logic [7:0] r_cks;
    logic       r_gcr_bad;
    logic       r_hdr_ok;
    logic [4:0] r_tmp_sec;
    logic [5:0] r_tmp_trk;
    logic       r_sec_ok;
    logic       r_trk_ok;

    logic       r_hdr_valid;
    logic       r_hdr_err;
    logic [4:0] r_hdr_sector;
    logic [5:0] r_hdr_track;
    logic [7:0] r_ram_addr;
    logic [7:0] r_ram_di;
    logic       r_ram_we;
    logic       r_sec_done;
    logic       r_sec_err;

    c1541_gcr_sync_det u_sync_det (
        .clk32         (clk32),
        .reset         (reset),
        .i_bit_en      (bus.bit_en),
        .i_bit_in      (bus.bit_in),
        .o_in_sync     (w_in_sync),
        .o_sync_stb    (w_sync_stb),
        .o_frame_start (w_frame_start),
        .o_byte_stb    (w_byte_stb),
        .o_code        (w_code)
    );

    assign w_hi      = gcr_decode(w_code[9:5]);
    assign w_lo      = gcr_decode(w_code[4:0]);
    assign w_byte    = {w_hi[3:0], w_lo[3:0]};
    assign w_code_ok = w_hi[4] & w_lo[4];
    // Include the byte being completed so a bad checksum byte counts too
    assign w_bad     = r_gcr_bad | ~w_code_ok;
    // Running XOR including the final byte must be zero
    assign w_cks_ok  = ((r_cks ^ w_byte) == 8'h00);

`ifdef C1541_GCR_DEC_TRACK_CHECK_EN
    assign w_trk_match = (w_byte == {2'b00, bus.track});
`else
    assign w_trk_match = 1'b1;
`endif

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            r_state      <= c_ST_HUNT;
            r_bytecnt    <= 9'd0;
            r_cks        <= 8'd0;
            r_gcr_bad    <= 1'b0;
            r_hdr_ok     <= 1'b0;
            r_tmp_sec    <= 5'd0;
            r_tmp_trk    <= 6'd0;
            r_sec_ok     <= 1'b0;
            r_trk_ok     <= 1'b0;
            r_hdr_valid  <= 1'b0;
            r_hdr_err    <= 1'b0;
            r_hdr_sector <= 5'd0;
            r_hdr_track  <= 6'd0;
            r_ram_addr   <= 8'd0;
            r_ram_di     <= 8'd0;
            r_ram_we     <= 1'b0;
            r_sec_done   <= 1'b0;
            r_sec_err    <= 1'b0;
        end else begin
            r_hdr_valid <= 1'b0;
            r_hdr_err   <= 1'b0;
            r_ram_we    <= 1'b0;
            r_sec_done  <= 1'b0;
            r_sec_err   <= 1'b0;

            if (w_sync_stb) begin
                // New sync aborts whatever block was in progress. Only an
                // interrupted data block is reported; its header is spent.
                r_gcr_bad <= 1'b0;
                if (r_state == c_ST_DATA) begin
                    r_sec_err <= 1'b1;
                    r_hdr_ok  <= 1'b0;
                end
                r_state <= c_ST_SYNC;
            end else begin
                if (w_byte_stb && !w_code_ok) begin
                    r_gcr_bad <= 1'b1;
                end

                case (r_state)
                    c_ST_SYNC: begin
                        if (w_frame_start) begin
                            r_state <= c_ST_ID;
                        end
                    end

                    c_ST_ID: begin
                        if (w_byte_stb) begin
                            r_bytecnt <= 9'd0;
                            r_cks     <= 8'd0;
                            if (w_byte == c_ID_HDR) begin
                                r_state <= c_ST_HDR;
                            end else if (w_byte == c_ID_DATA && r_hdr_ok) begin
                                r_state <= c_ST_DATA;
                            end else begin
                                r_state <= c_ST_SKIP;
                            end
                        end
                    end

                    // Byte order: cks, sector, track, id2, id1
                    c_ST_HDR: begin
                        if (w_byte_stb) begin
                            r_cks     <= r_cks ^ w_byte;
                            r_bytecnt <= r_bytecnt + 9'd1;
                            case (r_bytecnt[2:0])
                                3'd1: begin
                                    r_tmp_sec <= w_byte[4:0];
                                    r_sec_ok  <= (w_byte <= c_MAX_SECTOR);
                                end
                                3'd2: begin
                                    r_tmp_trk <= w_byte[5:0];
                                    r_trk_ok  <= w_trk_match;
                                end
                                3'd4: begin
                                    if (w_cks_ok && !w_bad && r_sec_ok && r_trk_ok) begin
                                        r_hdr_valid  <= 1'b1;
                                        r_hdr_sector <= r_tmp_sec;
                                        r_hdr_track  <= r_tmp_trk;
                                        r_hdr_ok     <= 1'b1;
                                    end else begin
                                        r_hdr_err <= 1'b1;
                                        r_hdr_ok  <= 1'b0;
                                    end
                                    r_state <= c_ST_SKIP;
                                end
                                default: ;
                            endcase
                        end
                    end

                    // 256 payload bytes, then the checksum byte
                    c_ST_DATA: begin
                        if (w_byte_stb) begin
                            if (!r_bytecnt[8]) begin
                                r_ram_we   <= 1'b1;
                                r_ram_addr <= r_bytecnt[7:0];
                                r_ram_di   <= w_byte;
                                r_cks      <= r_cks ^ w_byte;
                                r_bytecnt  <= r_bytecnt + 9'd1;
                            end else begin
                                if (w_cks_ok && !w_bad) begin
                                    r_sec_done <= 1'b1;
                                end else begin
                                    r_sec_err <= 1'b1;
                                end
                                r_hdr_ok <= 1'b0;
                                r_state  <= c_ST_SKIP;
                            end
                        end
                    end

                    default: ;  // HUNT and SKIP wait for sync
                endcase
            end
        end
    end

    assign bus.in_sync    = w_in_sync;
    assign bus.hdr_valid  = r_hdr_valid;
    assign bus.hdr_err    = r_hdr_err;
    assign bus.hdr_sector = r_hdr_sector;
    assign bus.hdr_track  = r_hdr_track;
    assign bus.ram_addr   = r_ram_addr;
    assign bus.ram_di     = r_ram_di;
    assign bus.ram_we     = r_ram_we;
    assign bus.sec_done   = r_sec_done;
    assign bus.sec_err    = r_sec_err;

endmodule
`default_nettype wire
